param_register_file: RTL
========================

// Module: param_register_file
// PURPOSE
//  Parametrised register file for the single-cycle datapath. It replaces the
//  fixed 8x8 file and provides 2 async read ports and 1 sync write port.
//  Adds same-cycle write-to-read bypass, an optional hardwired-zero R0,
//  single-register clear, and a sequenced clear-all engine with a busy flag.
//  Sits between the decoder (addresses) and the ALU/writeback path.
// PARAMETERS
//  DATA_W    8           bits per register
//  ADDR_W    3           address bits
//  DEPTH     1<<ADDR_W   number of registers; legal range 2..(1<<ADDR_W)
//  ZERO_REG  0           1: R0 always reads 0 and ignores writes/clears
//  BYPASS    1           1: a read of the address being written returns wdata
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  reset_n      in   1       async, active-low reset
//  we           in   1       write enable
//  waddr        in   ADDR_W  write/clear address
//  wdata        in   DATA_W  write data
//  clr_one      in   1       clear register[waddr] at the next edge
//  clr_all_req  in   1       start the clear-all sweep (sampled in IDLE only)
//  busy         out  1       high while the sweep runs
//  raddr_a      in   ADDR_W  read address A
//  raddr_b      in   ADDR_W  read address B
//  rdata_a      out  DATA_W  read data A (combinational)
//  rdata_b      out  DATA_W  read data B (combinational)
// BEHAVIOUR
//  - Reset (reset_n=0, async): all registers 0, FSM=IDLE, sweep idx=0, busy=0.
//    Reads during reset return 0.
//  - FSM IDLE:
//    - clr_one=1: reg[waddr]<=0 at the edge. clr_one wins over a same-cycle we.
//    - else we=1: reg[waddr]<=wdata at the edge.
//    - clr_all_req=1: go to SWEEP at the edge, idx<=0. A same-cycle
//      we/clr_one still executes at that edge.
//  - FSM SWEEP, busy=1:
//    - Each edge: reg[idx]<=0 and idx++. When idx==DEPTH-1, return to IDLE.
//    - busy is high for exactly DEPTH cycles.
//    - we, clr_one and clr_all_req are ignored (dropped, not queued).
//  - Reads:
//    - rdata_x = reg[raddr_x]; 0 if raddr_x>=DEPTH.
//    - 0 if ZERO_REG=1 and raddr_x=0.
//    - Bypass: if BYPASS=1, busy=0, we=1, clr_one=0 and waddr==raddr_x,
//      then rdata_x = wdata (same cycle).
//    - Bypass does not apply during SWEEP, to clr_one, or to R0 when ZERO_REG=1.
//  - Latency:
//    - Without bypass, a write is visible on the read ports 1 cycle after the edge.
//    - Both ports may read the same address at once.
//  - Boundaries:
//    - Writes to waddr>=DEPTH are ignored.
//    - reset_n low mid-sweep aborts immediately: busy=0 and all registers 0.
// TESTING
//  1. Reset with reset_n=0 for 2 cycles, then release -> every address reads
//     0 on both ports; busy=0.
//  2. Write 8'hAA+i to addr i=0..7 (ZERO_REG=0). Read a=i, b=7-i the next
//     cycle -> rdata_a=AA+i, rdata_b=AA+7-i.
//  3. reg3=8'h11; we=1 waddr=3 wdata=8'h5C raddr_a=3 -> before the edge,
//     rdata_a=5C (BYPASS=1) or 11 (BYPASS=0); after the edge, 5C in both cases.
//  4. we=1 clr_one=1 waddr=2 wdata=FF -> reg2 reads 00. Then, with ZERO_REG=1,
//     we=1 waddr=0 wdata=77 -> R0 reads 00.
//  5. Pulse clr_all_req with all regs loaded -> busy=1 for exactly 8 cycles.
//     A we to addr 5 mid-sweep is dropped. All regs read 0 after; busy=0.
//  6. Assert reset_n=0 at sweep cycle 3, asynchronously to clk -> busy falls
//     without waiting for an edge, all regs 0. After release, a write to
//     addr 1 works normally.

Source files
------------

// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// same-cycle write bypass, optional hardwired-zero R0, single clear and a clear-all sweep.
module param_register_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DEPTH    = 1 << ADDR_W,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_one,
  input  logic              clr_all_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              waddr_ok;
  logic              bypass_en;

  assign waddr_ok = ({1'b0, waddr} < DepthW);

  // Addresses at or above DEPTH simply never match a register index.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (state_q == StSweep) begin
        if (idx_q == i[ADDR_W-1:0]) begin
          regs_d[i] = '0;
        end
      end else if ((waddr == i[ADDR_W-1:0]) && !(ZERO_REG && (i == 0))) begin
        if (clr_one) begin
          regs_d[i] = '0;
        end else if (we) begin
          regs_d[i] = wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_all_req) begin
            state_q <= StSweep;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // reset_n gates the bypass so reads stay zero while reset is held.
  assign bypass_en = BYPASS && reset_n && !busy_q && we && !clr_one && waddr_ok;

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (raddr[p] == i[ADDR_W-1:0]) begin
          rdata[p] = regs_q[i];
        end
      end
      if (ZERO_REG && (raddr[p] == '0)) begin
        rdata[p] = '0;
      end else if (bypass_en && (waddr == raddr[p])) begin
        rdata[p] = wdata;
      end
    end
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

endmodule
